alarm_siren_ctrl: RTL and testbench
===================================

ALARM_SIREN_CTRL -- requirements
Module: alarm_siren_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive high samples of alarma_in needed to trigger (legal >=1).
REQ-002 SHALL have parameter SIREN_CYCLES, default 1000: maximum siren-active duration in cycles (legal >=1).
REQ-003 SHALL have parameter BLINK_HALF, default 50: blink half-period in cycles (legal >=1).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alarma_in  input  1  raw alarm request from the upstream sensor combiner, (m&ta)|tb.
REQ-007 armed  input  1  level; 1 = system armed.
REQ-008 ack  input  1  acknowledge; a 1-cycle pulse is sufficient.
REQ-009 siren  output  1  siren drive.
REQ-010 alarm_latched  output  1  alarm event occurred and not yet acknowledged.
REQ-011 state  output  3  current FSM state code.

Function
REQ-012 FSM states and codes SHALL be: DISARMED=0, ARMED=1, QUALIFY=2, SIREN=3, SILENT=4.
REQ-013 In DISARMED, armed=1 SHALL move to ARMED; all other inputs are ignored.
REQ-014 In ARMED:
- armed=0 -> DISARMED.
- Otherwise alarma_in=1 -> QUALIFY with debounce count=1.
- If DEBOUNCE_CYCLES=1, alarma_in=1 -> SIREN directly.
REQ-015 In QUALIFY, in priority order:
- armed=0 -> DISARMED.
- alarma_in=0 -> ARMED, count cleared.
- Otherwise count increments; on the edge where the count reaches DEBOUNCE_CYCLES -> SIREN.
REQ-016 SIREN SHALL be entered on the DEBOUNCE_CYCLES-th consecutive rising edge at which alarma_in is sampled high.
REQ-017 In SIREN:
- ack=1 -> ARMED if armed=1, else DISARMED.
- Else, after SIREN_CYCLES cycles in SIREN -> SILENT.
- ack has priority over timeout on the same edge.
- armed=0 alone SHALL NOT leave SIREN.
REQ-018 In SILENT, ack=1 SHALL exit to ARMED or DISARMED per armed; alarma_in SHALL be ignored (no re-trigger).
REQ-019 ack in DISARMED, ARMED or QUALIFY SHALL have no effect.
REQ-020 siren SHALL be 1 only in SIREN, for at most SIREN_CYCLES cycles per event.
REQ-021 alarm_latched SHALL be 1 exactly while in SIREN or SILENT.
REQ-022 All outputs SHALL be registered and derived from state/counters, changing on the same edge as the state.
REQ-023 Counters SHALL be $clog2(max+1) bits wide, SHALL saturate and never wrap, and SHALL clear on every state entry.

Reset
REQ-024 rst SHALL have priority over all inputs including ack.
REQ-025 Reset values: state=DISARMED, siren=0, alarm_latched=0, all counters 0.
REQ-026 rst asserted mid-SIREN SHALL drop siren and alarm_latched at that same edge.

Configuration
REQ-027 With macro SIREN_BLINK_EN defined, siren in SIREN SHALL toggle every BLINK_HALF cycles:
- high for the first BLINK_HALF cycles after entry, then low, repeating.
- SIREN total duration unchanged (SIREN_CYCLES).
REQ-028 With SIREN_BLINK_EN undefined, siren SHALL be continuously 1 in SIREN and BLINK_HALF is unused.

Structure
REQ-029 Shared package alarm_pkg SHALL hold:
- state enum typedef.
- state width constant (3).
- default constants for DEBOUNCE_CYCLES, SIREN_CYCLES, BLINK_HALF.
REQ-030 One sub-module, alarm_timer, SHALL be used: a clearable saturating up-counter with terminal-count flag, instantiated for the siren duration and the blink phase.

Verification (DEBOUNCE_CYCLES=4, SIREN_CYCLES=10, BLINK_HALF=2)
REQ-031 armed=1, alarma_in high 3 cycles then low -> siren stays 0, state returns to 1.
REQ-032 armed=1, alarma_in held high -> siren=1 and alarm_latched=1 after the 4th sampling edge; siren stays 1 for 10 cycles, then state=4, siren=0, alarm_latched=1.
REQ-033 Ack during SIREN:
- 1-cycle ack pulse at SIREN cycle 5, armed=1 -> next edge siren=0, alarm_latched=0, state=1.
- Same with armed=0 -> state=0.
REQ-034 armed drops to 0 during QUALIFY -> state=0, siren never asserts; armed=0 in SIREN without ack -> siren continues.
REQ-035 rst pulse at SIREN cycle 3 -> at that edge siren=0, alarm_latched=0, state=0.
REQ-036 SIREN_BLINK_EN defined -> siren over the 10 SIREN cycles = 1,1,0,0,1,1,0,0,1,1, then 0 with state=4.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm siren controller.
package alarm_pkg;

  localparam int STATE_W = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SIREN_CYCLES    = 1000;
  localparam int DEF_BLINK_HALF      = 50;

  typedef enum logic [STATE_W-1:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    QUALIFY  = 3'd2,
    SIREN    = 3'd3,
    SILENT   = 3'd4
  } state_t;

endpackage

// File: rtl/alarm_timer.sv
// Clearable saturating up-counter; tc flags the last cycle of a MAX-cycle interval.
module alarm_timer #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

  // Asserted while the count sits on its final value, so the owner can act on that edge.
  assign tc = (count == W'(MAX - 1));

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Armed/debounce/siren/silent alarm controller with registered outputs.
// Defining SIREN_BLINK_EN makes the siren blink with half-period BLINK_HALF.
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SIREN_CYCLES    = DEF_SIREN_CYCLES,
  parameter int BLINK_HALF      = DEF_BLINK_HALF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alarma_in,
  input  logic               armed,
  input  logic               ack,
  output logic               siren,
  output logic               alarm_latched,
  output logic [STATE_W-1:0] state
);

  if ((DEBOUNCE_CYCLES < 1) || (SIREN_CYCLES < 1) || (BLINK_HALF < 1)) begin : g_bad_params
    $error("alarm_siren_ctrl: DEBOUNCE_CYCLES, SIREN_CYCLES and BLINK_HALF must all be >= 1");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  state_t          state_q, state_d;
  logic [DB_W-1:0] deb_q, deb_d;
  logic            siren_d, latched_d;
  logic            entry, in_siren, dur_tc, siren_on;

  assign entry    = (state_d != state_q);
  assign in_siren = (state_q == SIREN);
  assign state    = state_q;

  alarm_timer #(.MAX(SIREN_CYCLES)) u_dur_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (entry),
    .en    (in_siren),
    .tc    (dur_tc)
  );

`ifdef SIREN_BLINK_EN
  logic phase_q, phase_d, blink_tc;

  // Restarting the phase timer at each half-period boundary keeps the blink period exact.
  alarm_timer #(.MAX(BLINK_HALF)) u_blink_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (entry | (in_siren & blink_tc)),
    .en    (in_siren),
    .tc    (blink_tc)
  );

  always_comb begin
    phase_d = phase_q;
    if (entry) begin
      phase_d = 1'b1;
    end else if (in_siren && blink_tc) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign siren_on = phase_d;
`else
  assign siren_on = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISARMED: begin
        if (armed) state_d = ARMED;
      end
      ARMED: begin
        if (!armed) begin
          state_d = DISARMED;
        end else if (alarma_in) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? SIREN : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!armed) begin
          state_d = DISARMED;
        end else if (!alarma_in) begin
          state_d = ARMED;
        end else if (deb_q >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = SIREN;
        end
      end
      SIREN: begin
        if (ack) begin
          state_d = armed ? ARMED : DISARMED;
        end else if (dur_tc) begin
          state_d = SILENT;
        end
      end
      SILENT: begin
        if (ack) state_d = armed ? ARMED : DISARMED;
      end
      default: state_d = DISARMED;
    endcase

    // Debounce count is 1 on QUALIFY entry (first high sample already seen), else 0.
    deb_d = '0;
    if (state_d == QUALIFY) begin
      if (state_q != QUALIFY) begin
        deb_d = DB_W'(1);
      end else if (deb_q != DB_W'(DEBOUNCE_CYCLES)) begin
        deb_d = deb_q + DB_W'(1);
      end else begin
        deb_d = deb_q;
      end
    end

    siren_d   = (state_d == SIREN) && siren_on;
    latched_d = (state_d == SIREN) || (state_d == SILENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DISARMED;
      deb_q         <= '0;
      siren         <= 1'b0;
      alarm_latched <= 1'b0;
    end else begin
      state_q       <= state_d;
      deb_q         <= deb_d;
      siren         <= siren_d;
      alarm_latched <= latched_d;
    end
  end

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Directed bench for alarm_siren_ctrl with a rule-level reference model and per-cycle compare.
module tb_alarm_siren_ctrl;
  import alarm_pkg::*;

  localparam int DEB   = 4;
  localparam int SCYC  = 10;
  localparam int BHALF = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               alarma_in = 1'b0;
  logic               armed = 1'b0;
  logic               ack = 1'b0;
  logic               siren;
  logic               alarm_latched;
  logic [STATE_W-1:0] state;

  int total = 0;
  int bad   = 0;

  alarm_siren_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SIREN_CYCLES    (SCYC),
    .BLINK_HALF      (BHALF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alarma_in     (alarma_in),
    .armed         (armed),
    .ack           (ack),
    .siren         (siren),
    .alarm_latched (alarm_latched),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Reference model: state number, consecutive-high streak, cycles completed in SIREN.
  int m_st = 0;
  int m_streak = 0;
  int m_age = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int n_st, n_streak, n_age;
    n_st = m_st;
    n_streak = m_streak;
    n_age = m_age;
    if (rst) begin
      n_st = 0; n_streak = 0; n_age = 0;
    end else begin
      case (m_st)
        0: if (armed) n_st = 1;
        1: begin
          if (!armed) n_st = 0;
          else if (alarma_in) begin
            n_streak = 1;
            if (n_streak >= DEB) begin n_st = 3; n_age = 0; end
            else n_st = 2;
          end
        end
        2: begin
          if (!armed) n_st = 0;
          else if (!alarma_in) begin n_st = 1; n_streak = 0; end
          else begin
            n_streak = m_streak + 1;
            if (n_streak >= DEB) begin n_st = 3; n_age = 0; end
          end
        end
        3: begin
          if (ack) n_st = armed ? 1 : 0;
          else begin
            n_age = m_age + 1;
            if (n_age >= SCYC) n_st = 4;
          end
        end
        4: if (ack) n_st = armed ? 1 : 0;
        default: n_st = 0;
      endcase
    end
    m_st     <= n_st;
    m_streak <= n_streak;
    m_age    <= n_age;
    m_valid  <= 1'b1;
  end

  function automatic int exp_siren();
    if (m_st != 3) return 0;
`ifdef SIREN_BLINK_EN
    return (((m_age / BHALF) % 2) == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  function automatic int exp_latched();
    return ((m_st == 3) || (m_st == 4)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_state", int'(state), m_st);
      check("cmp_siren", int'(siren), exp_siren());
      check("cmp_latched", int'(alarm_latched), exp_latched());
    end
  end

  // Apply one set of inputs for exactly one sampling edge.
  task automatic cyc(input logic a, input logic arm, input logic k, input logic r);
    alarma_in = a;
    armed = arm;
    ack = k;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n, input logic a, input logic arm);
    for (int i = 0; i < n; i++) cyc(a, arm, 1'b0, 1'b0);
  endtask

  task automatic lit(input string name, input int exp_state, input int exp_siren_v, input int exp_latched_v);
    check({name, "_state"}, int'(state), exp_state);
    check({name, "_siren"}, int'(siren), exp_siren_v);
    check({name, "_latched"}, int'(alarm_latched), exp_latched_v);
    check({name, "_model"}, m_st, exp_state);
  endtask

  initial begin
    int blink_age3;
`ifdef SIREN_BLINK_EN
    blink_age3 = 0;
`else
    blink_age3 = 1;
`endif
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    lit("reset", 0, 0, 0);

    // Short burst of 3 highs falls back to ARMED.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit("armed", 1, 0, 0);
    cycn(3, 1'b1, 1'b1);
    lit("qualify3", 2, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit("burst_drop", 1, 0, 0);

    // Held high: SIREN on 4th edge, 10 cycles, then SILENT; no re-trigger.
    cycn(3, 1'b1, 1'b1);
    lit("pre_trigger", 2, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    lit("trigger", 3, 1, 1);
    cycn(9, 1'b1, 1'b1);
    lit("siren_last", 3, 1, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    lit("timeout", 4, 0, 1);
    cycn(6, 1'b1, 1'b1);
    lit("silent_hold", 4, 0, 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    lit("silent_ack", 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    lit("ack_in_armed", 1, 0, 0);

    // Ack at SIREN cycle 5 with armed=1, then with armed=0.
    cycn(4, 1'b1, 1'b1);
    lit("trigger2", 3, 1, 1);
    cycn(4, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    lit("ack_armed", 1, 0, 0);
    cycn(4, 1'b1, 1'b1);
    cycn(4, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    lit("ack_disarmed", 0, 0, 0);

    // Disarm during QUALIFY; ack in QUALIFY is ignored; disarm alone in SIREN keeps it on.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cycn(2, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    lit("ack_in_qualify", 2, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit("disarm_qualify", 0, 0, 0);
    cycn(5, 1'b1, 1'b0);
    lit("disarmed_ignore", 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cycn(4, 1'b1, 1'b1);
    lit("trigger3", 3, 1, 1);
    cycn(3, 1'b0, 1'b0);
    lit("disarm_in_siren", 3, blink_age3, 1);
    cycn(7, 1'b0, 1'b0);
    lit("timeout_disarmed", 4, 0, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    lit("silent_ack_dis", 0, 0, 0);

    // Reset mid-SIREN, with ack also high, clears everything on that edge.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cycn(4, 1'b1, 1'b1);
    cycn(2, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    lit("rst_mid_siren", 0, 0, 0);
    cycn(3, 1'b0, 1'b1);
    lit("post_reset_arm", 1, 0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
